// File: rtl/mascarenhas_t_flip_flop_pkg.sv
// Shared constants for the T flip-flop bank tile.
// Control bit positions on uio_in and output-enable pattern.
package mascarenhas_t_flip_flop_pkg;

    localparam int UIO_HOLD_BIT  = 0;
    localparam int UIO_CLEAR_BIT = 1;
    localparam int UIO_SET_BIT   = 2;
    localparam int CNT_WIDTH     = 4;

    localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

    // Counter sits in the driven upper nibble; lower nibble reads as 0.
    function automatic logic [7:0] pack_uio_out(
        input logic [CNT_WIDTH-1:0] cnt
    );
        return {cnt, 4'b0000};
    endfunction

endpackage

// File: rtl/mascarenhas_t_flip_flop_tff_cell.sv
// Single T flip-flop with sync reset, enable, clear and set.
// Priority: rst, then enable, then clear, then set, then toggle.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic set,
    input  logic t,
    output logic q
);

    // State update in strict priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            if (clr) begin
                q <= 1'b0;
            end else if (set) begin
                q <= 1'b1;
            end else if (t) begin
                q <= ~q;
            end
        end
    end

endmodule

// File: rtl/mascarenhas_t_flip_flop.sv
// Eight-bit T flip-flop bank with a toggle-event counter.
// Control decode, counter and pin muxing live here.
module mascarenhas_t_flip_flop
    import mascarenhas_t_flip_flop_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic                 hold;
    logic                 clr;
    logic                 set;
    logic [7:0]           q;
    logic [7:0]           t_eff;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 unused_uio;

    assign hold       = uio_in[UIO_HOLD_BIT];
    assign clr        = uio_in[UIO_CLEAR_BIT];
    assign set        = uio_in[UIO_SET_BIT];
    assign unused_uio = ^uio_in[7:3];

    // Hold masks toggles; clear and set inside the cell still win.
    assign t_eff = hold ? 8'h00 : ui_in;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_cell
            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .en  (ena),
                .clr (clr),
                .set (set),
                .t   (t_eff[i]),
                .q   (q[i])
            );
        end
    endgenerate

    // Count cycles in which any bit actually toggled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ena) begin
            if (clr) begin
                cnt <= '0;
            end else if (!set && !hold && (ui_in != 8'h00)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign uo_out  = q;
    assign uio_out = pack_uio_out(cnt);
    assign uio_oe  = UIO_OE_VALUE;

endmodule

// File: tb/tb_mascarenhas_t_flip_flop.sv
// Self-checking bench for the T flip-flop bank tile.
// Directed vector table, counter wrap sequence, random vs model.
module tb_mascarenhas_t_flip_flop;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;

    mascarenhas_t_flip_flop dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ena;
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[18];

    // Behavioural model state
    int m_q;
    int m_cnt;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic e,
                         input logic [7:0] u, input logic [7:0] c);
        rst    = r;
        ena    = e;
        ui_in  = u;
        uio_in = c;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_step(input logic r, input logic e,
                                       input logic [7:0] u,
                                       input logic [7:0] c);
        if (r) begin
            m_q   = 0;
            m_cnt = 0;
        end else if (!e) begin
            m_q = m_q;
        end else if (c[1]) begin
            m_q   = 0;
            m_cnt = 0;
        end else if (c[2]) begin
            m_q = 255;
        end else if (c[0]) begin
            m_q = m_q;
        end else begin
            m_q = m_q ^ int'(u);
            if (u != 0) m_cnt = (m_cnt + 1) % 16;
        end
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'h00;

        //          rst   ena   ui     uio    uo     uio_out
        vecs[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h10};
        vecs[3]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'h20};
        vecs[4]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h30};
        vecs[5]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'h40};
        vecs[6]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'h50};
        vecs[7]  = '{1'b0, 1'b1, 8'h0F, 8'h00, 8'hAA, 8'h60};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hAA, 8'h60};
        vecs[9]  = '{1'b0, 1'b1, 8'hFF, 8'h07, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 8'hFF, 8'h05, 8'hFF, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 8'h0F, 8'h00, 8'hF0, 8'h10};
        vecs[13] = '{1'b0, 1'b0, 8'hFF, 8'h02, 8'hF0, 8'h10};
        vecs[14] = '{1'b0, 1'b0, 8'hFF, 8'h02, 8'hF0, 8'h10};
        vecs[15] = '{1'b0, 1'b0, 8'hFF, 8'h02, 8'hF0, 8'h10};
        vecs[16] = '{1'b1, 1'b0, 8'h3C, 8'h04, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 8'h03, 8'hF8, 8'h03, 8'h10};

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].rst, vecs[i].ena, vecs[i].ui, vecs[i].uio);
            check($sformatf("vec%0d_uo_out", i), uo_out, vecs[i].exp_uo);
            check($sformatf("vec%0d_uio_out", i), uio_out, vecs[i].exp_uio);
            check($sformatf("vec%0d_uio_oe", i), uio_oe, 8'hF0);
        end

        // Counter wrap: 17 toggle cycles of bit 7 from reset
        apply(1'b1, 1'b1, 8'h80, 8'h00);
        check("wrap_reset_uo", uo_out, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            logic [7:0] eq;
            logic [3:0] ec;
            apply(1'b0, 1'b1, 8'h80, 8'h00);
            eq = (k % 2 == 1) ? 8'h80 : 8'h00;
            ec = 4'(k % 16);
            check($sformatf("wrap%0d_uo", k), uo_out, eq);
            check($sformatf("wrap%0d_cnt", k), uio_out, {ec, 4'h0});
        end

        // Random stimulus against the model
        m_q   = 0;
        m_cnt = 0;
        apply(1'b1, 1'b1, 8'h00, 8'h00);
        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic       e;
            logic [7:0] u;
            logic [7:0] c;
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 7) != 0);
            u = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            c = {5'($urandom), 3'b000};
            if ($urandom_range(0, 9) == 0) c[0] = 1'b1;
            if ($urandom_range(0, 14) == 0) c[1] = 1'b1;
            if ($urandom_range(0, 11) == 0) c[2] = 1'b1;
            apply(r, e, u, c);
            model_step(r, e, u, c);
            check($sformatf("rnd%0d_uo", n), uo_out, 8'(m_q));
            check($sformatf("rnd%0d_uio", n), uio_out,
                  {4'(m_cnt), 4'h0});
        end
        check("final_uio_oe", uio_oe, 8'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
